// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between NUM_REQ writeback
// requesters (e.g. ALU, mult/div, load return) using round-robin arbitration
// with per-requester valid/ready handshakes. The winning request is
// registered and drives the write port one cycle after acceptance. Writes
// that target r0 are accepted but never enable the write port.
//
// Ports:
//   clock            in   system clock
//   ctrl_reset       in   asynchronous, active-high reset
//   req_valid        in   [NUM_REQ]         per-requester request valid
//   req_reg          in   [NUM_REQ*ADDR_W]  destination, slice i = [i*ADDR_W +: ADDR_W]
//   req_data         in   [NUM_REQ*DATA_W]  write data,  slice i = [i*DATA_W +: DATA_W]
//   req_ready        out  [NUM_REQ]         accept, one-hot or zero (combinational)
//   wb_hold          in   blocks any new acceptance
//   ctrl_writeEnable out  regfile write enable
//   ctrl_writeReg    out  [ADDR_W]  regfile write index
//   data_writeReg    out  [DATA_W]  regfile write data
//   grant_id         out  [3]       requester accepted in the previous cycle
//   grant_valid      out  grant_id is meaningful
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_hold,
    output logic                      ctrl_writeEnable,
    output logic [ADDR_W-1:0]         ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg,
    output logic [2:0]                grant_id,
    output logic                      grant_valid
);

    // Round-robin pointer: the requester with highest priority this cycle.
    logic [2:0]        rr_ptr_q, rr_ptr_d;

    logic              we_q;
    logic [ADDR_W-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        grant_id_q;
    logic              grant_valid_q;

    // Arbitration result for the current cycle.
    logic              grant_found;
    logic [2:0]        grant_idx;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    int                scan_pos;

    // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and take the first valid one.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_reg     = '0;
        sel_data    = '0;
        scan_pos    = 0;
        if (!wb_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_pos = int'(rr_ptr_q) + k;
                if (scan_pos >= NUM_REQ) begin
                    scan_pos = scan_pos - NUM_REQ;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!grant_found && (i == scan_pos) && req_valid[i]) begin
                        grant_found = 1'b1;
                        grant_idx   = 3'(i);
                        sel_reg     = req_reg[i*ADDR_W +: ADDR_W];
                        sel_data    = req_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_found && (grant_idx == 3'(i));
        end
    end

    // Pointer moves just past the winner; it holds when nothing transfers.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_found) begin
            rr_ptr_d = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            rr_ptr_q      <= '0;
            we_q          <= 1'b0;
            wreg_q        <= '0;
            wdata_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            rr_ptr_q      <= rr_ptr_d;
            we_q          <= grant_found && (sel_reg != '0);
            grant_valid_q <= grant_found;
            // Index/data hold when idle; they are don't-care with the enable low.
            if (grant_found) begin
                wreg_q     <= sel_reg;
                wdata_q    <= sel_data;
                grant_id_q <= grant_idx;
            end
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign grant_id         = grant_id_q;
    assign grant_valid      = grant_valid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter (NUM_REQ=3, DATA_W=32, ADDR_W=5).
// Inputs change on the falling edge; req_ready is sampled 1 ns later and the
// registered write port 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic              clock;
    logic              ctrl_reset;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_reg;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              wb_hold;
    logic              ctrl_writeEnable;
    logic [AW-1:0]     ctrl_writeReg;
    logic [DW-1:0]     data_writeReg;
    logic [2:0]        grant_id;
    logic              grant_valid;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .req_valid        (req_valid),
        .req_reg          (req_reg),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .wb_hold          (wb_hold),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .grant_id         (grant_id),
        .grant_valid      (grant_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_port(input string tag, input logic we, input logic [AW-1:0] r,
                              input logic [DW-1:0] d, input logic [2:0] gid, input logic gv);
        check({tag, ".we"},    64'(ctrl_writeEnable), 64'(we));
        check({tag, ".reg"},   64'(ctrl_writeReg),    64'(r));
        check({tag, ".data"},  64'(data_writeReg),    64'(d));
        check({tag, ".gid"},   64'(grant_id),         64'(gid));
        check({tag, ".gv"},    64'(grant_valid),      64'(gv));
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_reg[i*AW +: AW]  = r;
        req_data[i*DW +: DW] = d;
    endtask

    // Drive point: falling edge. Ready sample: 1 ns later.
    task automatic to_drive();
        @(negedge clock);
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        ctrl_reset = 1'b1;
        wb_hold    = 1'b0;
        req_valid  = '0;
        req_reg    = '0;
        req_data   = '0;

        // ---- Reset state ----
        #2;
        check_port("reset", 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
        check("reset.ready", 64'(req_ready), 64'(3'b000));

        to_drive();
        ctrl_reset = 1'b0;

        // ---- req0 alone: reg 5, 0xDEADBEEF (rr 0 -> 1) ----
        set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        check("single.ready", 64'(req_ready), 64'(3'b001));
        after_edge();
        check_port("single", 1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0, 1'b1);

        // ---- req1 to r0: accepted, no write enable (rr 1 -> 2) ----
        to_drive();
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b1, 5'd0, 32'h1234);
        #1;
        check("r0.ready", 64'(req_ready), 64'(3'b010));
        after_edge();
        check("r0.we",  64'(ctrl_writeEnable), 64'(1'b0));
        check("r0.gv",  64'(grant_valid),      64'(1'b1));
        check("r0.gid", 64'(grant_id),         64'(3'd1));

        // ---- req2 alone brings rr back to 0 ----
        to_drive();
        set_req(1, 1'b0, 5'd0, 32'h0);
        set_req(2, 1'b1, 5'd9, 32'h99);
        #1;
        check("req2.ready", 64'(req_ready), 64'(3'b100));
        after_edge();
        check_port("req2", 1'b1, 5'd9, 32'h99, 3'd2, 1'b1);

        // ---- All three continuously valid: grants 0,1,2,0,1,2 ----
        to_drive();
        set_req(0, 1'b1, 5'd1, 32'h11);
        set_req(1, 1'b1, 5'd2, 32'h22);
        set_req(2, 1'b1, 5'd3, 32'h33);
        for (int k = 0; k < 6; k++) begin
            logic [2:0] g;
            logic [2:0] one_hot;
            g       = 3'(k % 3);
            one_hot = 3'b001 << g;
            #1;
            check($sformatf("rr%0d.ready", k), 64'(req_ready), 64'(one_hot));
            after_edge();
            check_port($sformatf("rr%0d", k), 1'b1, 5'(g + 3'd1),
                       32'(8'h11 * (g + 3'd1)), g, 1'b1);
            to_drive();
        end

        // ---- Idle cycle: enable drops, index/data hold ----
        req_valid = '0;
        #1;
        check("idle.ready", 64'(req_ready), 64'(3'b000));
        after_edge();
        check_port("idle", 1'b0, 5'd3, 32'h33, 3'd2, 1'b0);

        // ---- Hold: in-flight write still issues, then acceptance blocked ----
        to_drive();
        set_req(0, 1'b1, 5'd6, 32'h66);
        after_edge();                       // req0 accepted, rr -> 1
        to_drive();
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(2, 1'b1, 5'd4, 32'h44);
        wb_hold = 1'b1;
        #1;
        check("hold.inflight_we", 64'(ctrl_writeEnable), 64'(1'b1));
        check("hold.inflight_reg", 64'(ctrl_writeReg), 64'(5'd6));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hold%0d.ready", k), 64'(req_ready), 64'(3'b000));
            after_edge();
            check($sformatf("hold%0d.we", k), 64'(ctrl_writeEnable), 64'(1'b0));
            check($sformatf("hold%0d.gv", k), 64'(grant_valid),      64'(1'b0));
            to_drive();
            if (k == 2) wb_hold = 1'b0;
            #1;
        end
        check("unhold.ready", 64'(req_ready), 64'(3'b100));
        after_edge();
        check_port("unhold", 1'b1, 5'd4, 32'h44, 3'd2, 1'b1);

        // ---- Same destination from req0/req2, invalid req1 carries junk ----
        to_drive();
        set_req(0, 1'b1, 5'd7, 32'hA);
        set_req(1, 1'b0, 5'd7, 32'hC);
        set_req(2, 1'b1, 5'd7, 32'hB);
        #1;
        check("same0.ready", 64'(req_ready), 64'(3'b001));
        after_edge();
        check_port("same0", 1'b1, 5'd7, 32'hA, 3'd0, 1'b1);
        to_drive();
        set_req(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("same1.ready", 64'(req_ready), 64'(3'b100));
        after_edge();
        check_port("same1", 1'b1, 5'd7, 32'hB, 3'd2, 1'b1);

        // ---- Reset right after req1 is accepted (rr would be 2) ----
        to_drive();
        set_req(1, 1'b0, 5'd0, 32'h0);
        set_req(2, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b1, 5'd8, 32'h88);
        #1;
        check("prerst.ready", 64'(req_ready), 64'(3'b010));
        after_edge();
        check("prerst.we", 64'(ctrl_writeEnable), 64'(1'b1));
        req_valid = '0;
        #1;
        ctrl_reset = 1'b1;
        #1;
        check_port("inrst", 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
        ctrl_reset = 1'b0;
        #1;
        check("postrst.we", 64'(ctrl_writeEnable), 64'(1'b0));
        to_drive();
        set_req(0, 1'b1, 5'd10, 32'hA0);
        set_req(1, 1'b1, 5'd8,  32'h88);
        set_req(2, 1'b1, 5'd11, 32'hB0);
        #1;
        check("postrst.ready", 64'(req_ready), 64'(3'b001));
        after_edge();
        check_port("postrst", 1'b1, 5'd10, 32'hA0, 3'd0, 1'b1);
        to_drive();
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
